// File: rtl/pipeline_drain_fifo.sv
// Drain buffer for a non-stallable fixed-latency pipeline stage.
// Launch credits go upstream only while a storage slot can be reserved for
// every launched item. Results are queued and leave on a valid/ready port.
`timescale 1ns/1ps
module pipeline_drain_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  inflight,
  output logic              err_sticky
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(DEPTH);

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nx;
  logic [CNT_W-1:0]  occ_nx;
  logic [DATA_W-1:0] head_nx;
  logic [CNT_W:0]    reserved;
  logic              launch;
  logic              accept;
  logic              illegal;
  logic              pop;

  // Credit depends on registered counters only; no path from up_valid/out_ready.
  assign reserved  = {1'b0, occupancy} + {1'b0, inflight};
  assign up_ready  = (reserved < DEPTH_C);
  assign out_valid = (occupancy != '0);
  assign launch    = up_valid && up_ready;
  assign accept    = in_valid && (inflight != '0);
  assign illegal   = in_valid && (inflight == '0);
  assign pop       = out_valid && out_ready;

  // Next read pointer, next occupancy and the head value to register for out_data.
  always_comb begin
    rd_ptr_nx = pop ? ptr_inc(rd_ptr) : rd_ptr;
    occ_nx    = occupancy;
    if (accept && !pop) occ_nx = occupancy + CNT_ONE;
    else if (!accept && pop) occ_nx = occupancy - CNT_ONE;
    head_nx = out_data;
    // An arriving item lands on the new head slot only when the queue was
    // (or becomes) otherwise empty, so take it directly from in_data then.
    if (accept && (wr_ptr == rd_ptr_nx)) head_nx = in_data;
    else if (occ_nx != '0)               head_nx = mem[rd_ptr_nx];
  end

  // Storage array: data only, written at the write pointer on accept.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= in_data;
  end

  // Counters, pointers, error flag and registered head-of-queue output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy  <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_sticky <= 1'b0;
      out_data   <= '0;
    end else begin
      occupancy <= occ_nx;
      rd_ptr    <= rd_ptr_nx;
      out_data  <= head_nx;
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (launch && !accept) inflight <= inflight + CNT_ONE;
      else if (!launch && accept) inflight <= inflight - CNT_ONE;
      if (illegal) err_sticky <= 1'b1;
    end
  end

  // Credit invariant: every stored or in-flight item owns a slot.
  a_no_overcommit: assert property (@(posedge clk) disable iff (!rst_n) reserved <= DEPTH_C);

endmodule

// File: tb/tb_pipeline_drain_fifo.sv
// Directed bench: drives pipeline_drain_fifo through a 2-cycle model of the
// upstream pipeline and checks counters, credit and result ordering.
`timescale 1ns/1ps
module tb_pipeline_drain_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up_valid;
  logic       up_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] occupancy;
  logic [2:0] inflight;
  logic       err_sticky;

  int errs   = 0;
  int checks = 0;

  // Pipeline model (never reset, so stale tokens survive a DUT reset).
  logic [1:0] pipe_v = '0;
  logic [7:0] pipe_d [2];
  logic [7:0] next_d = 8'h11;
  logic       inj_v  = 1'b0;
  logic [7:0] inj_d  = '0;
  int         launches = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  assign in_valid = pipe_v[1] | inj_v;
  assign in_data  = inj_v ? inj_d : pipe_d[1];

  pipeline_drain_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
    .inflight(inflight), .err_sticky(err_sticky)
  );

  // Upstream pipeline, launch/pop monitor and expected-order scoreboard.
  always @(posedge clk) begin
    pipe_v[0] <= up_valid && up_ready && rst_n;
    pipe_d[0] <= next_d;
    pipe_v[1] <= pipe_v[0];
    pipe_d[1] <= pipe_d[0];
    if (up_valid && up_ready && rst_n) begin
      launches <= launches + 1;
      exp_q.push_back(next_d);
      next_d <= next_d + 8'h11;
    end
    if (out_valid && out_ready && rst_n) got_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic compare_order(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_item%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int max_occ;
    logic [7:0] drain_exp [4];
    drain_exp = '{8'h11, 8'h22, 8'h33, 8'h44};

    // 1 Reset
    rst_n = 1'b0; up_valid = 1'b0; out_ready = 1'b0;
    cyc(3);
    check("rst_up_ready", up_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_inflight", inflight, 0);
    check("rst_err", err_sticky, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    // 2 Fill: latency 2, no draining
    up_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (i == 3) check("fill_up_ready_before_last", up_ready, 1);
      if (i == 4) begin
        check("fill_launches", launches, 4);
        check("fill_up_ready_low", up_ready, 0);
      end
      if (i == 5) check("fill_occ_at5", occupancy, 3);
      if (i == 6) check("fill_occ_at6", occupancy, 4);
    end
    check("fill_launch_total", launches, 4);
    check("fill_inflight", inflight, 0);
    check("fill_out_valid", out_valid, 1);
    check("fill_out_data", out_data, 8'h11);
    check("fill_err", err_sticky, 0);
    up_valid = 1'b0;

    // 3 Drain order
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_valid%0d", k), out_valid, 1);
      check($sformatf("drain_data%0d", k), out_data, drain_exp[k]);
      check($sformatf("drain_up_ready%0d", k), up_ready, (k == 0) ? 0 : 1);
      cyc(1);
    end
    check("drain_empty", out_valid, 0);
    check("drain_occ", occupancy, 0);
    compare_order("drain_order");

    // 4 Streaming
    base = launches;
    max_occ = 0;
    up_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (occupancy > max_occ) max_occ = occupancy;
    end
    check("stream_launches", launches - base, 20);
    up_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (occupancy > max_occ) max_occ = occupancy;
    end
    check("stream_max_occ", max_occ, 1);
    compare_order("stream_order");

    // 5 Full, then concurrent pop/launch with pointer wrap over 12 items
    out_ready = 1'b0;
    up_valid  = 1'b1;
    cyc(8);
    check("full_occ", occupancy, 4);
    check("full_inflight", inflight, 0);
    base = launches;
    for (int i = 0; i < 60; i++) begin
      if (launches - base >= 8) up_valid = 1'b0;
      out_ready = (i % 3 != 2);
      cyc(1);
    end
    check("wrap_launches", launches - base, 8);
    out_ready = 1'b1;
    cyc(8);
    check("wrap_occ", occupancy, 0);
    check("wrap_inflight", inflight, 0);
    check("wrap_items", got_q.size(), 12);
    compare_order("wrap_order");

    // 6 Illegal arrival
    inj_d = 8'hAA; inj_v = 1'b1;
    cyc(1);
    inj_v = 1'b0;
    cyc(1);
    check("illegal_err", err_sticky, 1);
    check("illegal_occ", occupancy, 0);
    check("illegal_inflight", inflight, 0);
    check("illegal_out_valid", out_valid, 0);
    rst_n = 1'b0;
    cyc(2);
    check("illegal_rst_clears", err_sticky, 0);
    rst_n = 1'b1;
    cyc(1);

    // Reset mid-operation: stale pipeline token arrives after reset
    up_valid = 1'b1;
    cyc(1);
    up_valid = 1'b0;
    check("midrst_inflight", inflight, 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    check("stale_err", err_sticky, 1);
    check("stale_occ", occupancy, 0);
    check("stale_inflight", inflight, 0);
    got_q.delete();
    exp_q.delete();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
